// File: rtl/regbank_wb_arbiter_if.sv
// Writeback bus between the NREQ writeback sources, the arbiter, and reg_bank's write port.
// The arbiter uses the slave view; whoever drives the requests uses the master view.
interface regbank_wb_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   clear_start;
  logic                   clear_busy;
  logic                   rf_write;
  logic [ADDR_W-1:0]      rf_des_reg;
  logic [DATA_W-1:0]      rf_write_data;

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ready, clear_busy, rf_write, rf_des_reg, rf_write_data
  );

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ready, clear_busy, rf_write, rf_des_reg, rf_write_data
  );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter for the register bank's single write port.
// It also has a clear sequencer that zeroes x1..x31 through the same port.
module regbank_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  regbank_wb_arbiter_if.slave wb
);
  localparam int PTR_W = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t                         state;
  logic [PTR_W-1:0]               rr_ptr;
  logic [PTR_W-1:0]               gnt_idx;
  logic                           found;
  logic [ADDR_W-1:0]              clr_idx;
  logic [NREQ-1:0][ADDR_W-1:0]    addr_l;
  logic [NREQ-1:0][DATA_W-1:0]    data_l;

  // Modulo-NREQ add; NREQ need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign addr_l[i] = wb.req_addr[i*ADDR_W +: ADDR_W];
    assign data_l[i] = wb.req_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && wb.req_valid[wrap_add(rr_ptr, k)]) begin
        found   = 1'b1;
        gnt_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  // Ready is combinational; a pending clear takes priority over every request.
  always_comb begin
    wb.req_ready = '0;
    if (reset_n && state == ARB && !wb.clear_start && found)
      wb.req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ARB;
      rr_ptr           <= '0;
      clr_idx          <= '0;
      wb.clear_busy    <= 1'b0;
      wb.rf_write      <= 1'b0;
      wb.rf_des_reg    <= '0;
      wb.rf_write_data <= '0;
    end else begin
      case (state)
        ARB: begin
          if (wb.clear_start) begin
            state         <= CLEAR;
            clr_idx       <= ADDR_W'(1);
            wb.clear_busy <= 1'b1;
            wb.rf_write   <= 1'b0;
          end else if (found) begin
            rr_ptr           <= wrap_add(gnt_idx, 1);
            wb.rf_write      <= (addr_l[gnt_idx] != '0);   // x0 is hardwired zero
            wb.rf_des_reg    <= addr_l[gnt_idx];
            wb.rf_write_data <= data_l[gnt_idx];
          end else begin
            wb.rf_write <= 1'b0;
          end
        end
        CLEAR: begin
          wb.rf_write      <= 1'b1;
          wb.rf_des_reg    <= clr_idx;
          wb.rf_write_data <= '0;
          if (clr_idx == LAST_IDX) begin
            state         <= ARB;
            wb.clear_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: vector table for arbitration plus hand sequences
// for the clear sequencer and reset during clear; rf outputs checked via scoreboard.
module tb_regbank_wb_arbiter;
  localparam int NREQ = 3, DW = 32, AW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regbank_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) bus ();
  regbank_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .wb(bus)
  );

  typedef struct {
    logic          wr;
    logic          busy;
    logic [AW-1:0] des;
    logic [DW-1:0] dat;
  } exp_t;

  typedef struct {
    logic [2:0]    v;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic          cs;
    logic [2:0]    rdy;
  } vec_t;

  exp_t sbq[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   m_clr = 0;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [AW-1:0] a0, a1, a2,
                       input logic [DW-1:0] d0, d1, d2, input logic cs);
    bus.req_valid   = v;
    bus.req_addr    = {a2, a1, a0};
    bus.req_data    = {d2, d1, d0};
    bus.clear_start = cs;
  endtask

  // Called just after a falling edge with inputs already driven; returns on the next falling edge.
  task automatic step(input string name, input logic [2:0] exp_rdy);
    exp_t e;
    #1;
    chk({name, " ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    if (m_clr != 0) begin
      cur.wr   = 1'b1;
      cur.des  = AW'(m_clr);
      cur.dat  = '0;
      cur.busy = (m_clr != 31);
      m_clr    = (m_clr == 31) ? 0 : m_clr + 1;
    end else if (bus.clear_start) begin
      cur.wr   = 1'b0;
      cur.busy = 1'b1;
      m_clr    = 1;
    end else begin
      cur.wr   = 1'b0;
      cur.busy = 1'b0;
      for (int g = 0; g < NREQ; g++) begin
        if (exp_rdy[g]) begin
          cur.des = bus.req_addr[g*AW +: AW];
          cur.dat = bus.req_data[g*DW +: DW];
          cur.wr  = (cur.des != '0);
        end
      end
    end
    sbq.push_back(cur);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({name, " rf_write"}, 32'(bus.rf_write), 32'(e.wr));
    chk({name, " clear_busy"}, 32'(bus.clear_busy), 32'(e.busy));
    if (e.wr) begin
      chk({name, " rf_des_reg"}, 32'(bus.rf_des_reg), 32'(e.des));
      chk({name, " rf_write_data"}, bus.rf_write_data, e.dat);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b111,  1,  2,  3, 32'hA0, 32'hA1, 32'hA2, 1'b0, 3'b001};
    tbl[1]  = '{3'b111,  4,  5,  6, 32'hB0, 32'hB1, 32'hB2, 1'b0, 3'b010};
    tbl[2]  = '{3'b111,  8,  9, 10, 32'hC0, 32'hC1, 32'hC2, 1'b0, 3'b100};
    tbl[3]  = '{3'b111, 11, 12, 13, 32'hD0, 32'hD1, 32'hD2, 1'b0, 3'b001};
    tbl[4]  = '{3'b111, 14, 15, 16, 32'hE0, 32'hE1, 32'hE2, 1'b0, 3'b010};
    tbl[5]  = '{3'b111, 17, 18, 19, 32'hF0, 32'hF1, 32'hF2, 1'b0, 3'b100};
    tbl[6]  = '{3'b010,  0,  7,  0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 3'b010};
    tbl[7]  = '{3'b011, 20, 21,  0, 32'h55, 32'h66, 32'h0, 1'b0, 3'b001};
    tbl[8]  = '{3'b000,  0,  0,  0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000};
    tbl[9]  = '{3'b101, 22,  0, 23, 32'h77, 32'h0, 32'h88, 1'b0, 3'b100};
    tbl[10] = '{3'b001,  0,  0,  0, 32'h1234, 32'h0, 32'h0, 1'b0, 3'b001};
    tbl[11] = '{3'b101, 24,  0, 25, 32'h99, 32'h0, 32'hAA, 1'b1, 3'b000};

    cur = '{1'b0, 1'b0, '0, '0};
    drive(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1'b0);
    #1;
    chk("reset ready", 32'(bus.req_ready), 32'h0);
    chk("reset rf_write", 32'(bus.rf_write), 32'h0);
    chk("reset clear_busy", 32'(bus.clear_busy), 32'h0);
    chk("reset rf_des_reg", 32'(bus.rf_des_reg), 32'h0);
    chk("reset rf_write_data", bus.rf_write_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].cs);
      step($sformatf("vec%0d", i), tbl[i].rdy);
    end

    // Clear sequence; a second clear_start mid-sequence must be ignored.
    for (int i = 0; i < 31; i++) begin
      drive(3'b101, 24, 0, 25, 32'h99, 32'h0, 32'hAA, i == 4);
      step($sformatf("clr%0d", i + 1), 3'b000);
    end
    // rr_ptr was 1 before the clear, so req2 wins, then req0.
    step("post_clear0", 3'b100);
    step("post_clear1", 3'b001);

    // Reset while clr_idx is 10.
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b1);
    step("clr2_start", 3'b000);
    for (int i = 0; i < 9; i++) begin
      drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
      step($sformatf("clr2_%0d", i + 1), 3'b000);
    end
    drive(3'b010, 0, 3, 0, 0, 32'h4242, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midclr reset rf_write", 32'(bus.rf_write), 32'h0);
    chk("midclr reset clear_busy", 32'(bus.clear_busy), 32'h0);
    chk("midclr reset ready", 32'(bus.req_ready), 32'h0);
    sbq.delete();
    m_clr = 0;
    cur = '{1'b0, 1'b0, '0, '0};
    @(negedge clk);
    reset_n = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("after_rst%0d", i), 3'b000);
    drive(3'b010, 0, 3, 0, 0, 32'h4242, 0, 1'b0);
    step("after_rst_g0", 3'b010);
    step("after_rst_g1", 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
